// File: rtl/ctrl_desplazamiento_if.sv
// Request/handshake and shift-register control bundle for ctrl_desplazamiento.
// slave = sequencer view, master = requester/environment view.
interface ctrl_desplazamiento_if #(
  parameter int N  = 4,
  parameter int CW = 3
);
  logic          REQ;
  logic [N-1:0]  D_IN;
  logic          DIR_IN;
  logic          ROT;
  logic [CW-1:0] CNT;
  logic          S_IN_EXT;
  logic          ACK;
  logic          BUSY;
  logic          DONE;
  logic          ENB;
  logic [1:0]    MODO;
  logic          DIR;
  logic [N-1:0]  D;
  logic          S_IN;

  modport slave (
    input  REQ, D_IN, DIR_IN, ROT, CNT, S_IN_EXT,
    output ACK, BUSY, DONE, ENB, MODO, DIR, D, S_IN
  );

  modport master (
    output REQ, D_IN, DIR_IN, ROT, CNT, S_IN_EXT,
    input  ACK, BUSY, DONE, ENB, MODO, DIR, D, S_IN
  );
endinterface

// File: rtl/ctrl_desplazamiento.sv
// Sequencer for the N-bit universal shift register: one parallel load followed
// by CNT shift/rotate steps, with ACK/BUSY/DONE handshake toward the requester.
module ctrl_desplazamiento #(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  ctrl_desplazamiento_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

  localparam logic [1:0] ModeLoad  = 2'b10;
  localparam logic [1:0] ModeShift = 2'b01;
  localparam logic [1:0] ModeRot   = 2'b00;

  state_t        state;
  logic [N-1:0]  word;
  logic          dirQ;
  logic          rotQ;
  logic [CW-1:0] cntQ;
  logic [CW-1:0] counter;

  logic          ackR;
  logic          busyR;
  logic          doneR;
  logic          enbR;
  logic [1:0]    modoR;
  logic          dirR;
  logic [N-1:0]  dR;

  // Outputs are registered: each branch loads the values for the state being entered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      word    <= '0;
      dirQ    <= 1'b0;
      rotQ    <= 1'b0;
      cntQ    <= '0;
      counter <= '0;
      ackR    <= 1'b0;
      busyR   <= 1'b0;
      doneR   <= 1'b0;
      enbR    <= 1'b0;
      modoR   <= ModeRot;
      dirR    <= 1'b0;
      dR      <= '0;
    end else begin
      ackR  <= 1'b0;
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          busyR <= 1'b0;
          enbR  <= 1'b0;
          modoR <= ModeRot;
          dirR  <= 1'b0;
          dR    <= '0;
          if (bus.REQ) begin
            state <= LOAD;
            word  <= bus.D_IN;
            dirQ  <= bus.DIR_IN;
            rotQ  <= bus.ROT;
            cntQ  <= bus.CNT;
            ackR  <= 1'b1;
            busyR <= 1'b1;
            enbR  <= 1'b1;
            modoR <= ModeLoad;
            dirR  <= bus.DIR_IN;
            dR    <= bus.D_IN;
          end
        end
        LOAD: begin
          counter <= cntQ;
          if (cntQ != '0) begin
            state <= SHIFT;
            enbR  <= 1'b1;
            modoR <= rotQ ? ModeRot : ModeShift;
          end else begin
            state <= FIN;
            enbR  <= 1'b0;
            modoR <= ModeRot;
            doneR <= 1'b1;
          end
        end
        SHIFT: begin
          counter <= counter - 1'b1;
          if (counter == CW'(1)) begin
            state <= FIN;
            enbR  <= 1'b0;
            modoR <= ModeRot;
            doneR <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busyR <= 1'b0;
          enbR  <= 1'b0;
          modoR <= ModeRot;
          dirR  <= 1'b0;
          dR    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ACK  = ackR;
  assign bus.BUSY = busyR;
  assign bus.DONE = doneR;
  assign bus.ENB  = enbR;
  assign bus.MODO = modoR;
  assign bus.DIR  = dirR;
  assign bus.D    = dR;
  // Serial fill follows the requester directly, gated to shift mode only.
  assign bus.S_IN = (modoR == ModeShift) ? bus.S_IN_EXT : 1'b0;

endmodule
